// File: rtl/fifo_pkg.sv
// Shared constants, Gray-code helpers and output-buffer state type for the async FIFO.
package fifo_pkg;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 8;
  localparam int PTR_W      = DEF_ADDR_W + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] gray);
    logic [PTR_W-1:0] bin;
    bin[PTR_W-1] = gray[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_read_ctrl_if.sv
// RAM read port plus FWFT output stream of the FIFO read side.
interface fifo_read_ctrl_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);

  logic              ren;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              rready;

  modport master (
    output ren, raddr, dout, dout_valid,
    input  rdata, rready
  );

  modport slave (
    input  ren, raddr, dout, dout_valid,
    output rdata, rready
  );

endinterface

// File: rtl/fifo_out_skid.sv
// Two-entry FWFT output buffer: dout holds the oldest word, skid catches one in-flight word.
module fifo_out_skid
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic              fetch,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              can_issue
);

  buf_state_t        state_reg, state_next;
  logic              fetch_pending_reg;
  logic [DATA_W-1:0] dout_reg, dout_next;
  logic [DATA_W-1:0] skid_reg, skid_next;
  logic [1:0]        held;
  logic [2:0]        occupancy;
  logic              pop;
  logic              arrive;

  assign dout_valid = (state_reg != EMPTY);
  assign dout       = dout_reg;
  assign pop        = dout_valid & rready;
  assign arrive     = fetch_pending_reg;

  // Words held plus the one already requested from RAM, less the one leaving now.
  assign occupancy = {1'b0, held} + {2'b00, fetch_pending_reg} - {2'b00, pop};
  assign can_issue = (occupancy < 3'd2);

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_reg         <= EMPTY;
      fetch_pending_reg <= 1'b0;
      dout_reg          <= '0;
      skid_reg          <= '0;
    end else begin
      state_reg         <= state_next;
      fetch_pending_reg <= fetch;
      dout_reg          <= dout_next;
      skid_reg          <= skid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    dout_next  = dout_reg;
    skid_next  = skid_reg;
    held       = 2'd0;
    case (state_reg)
      EMPTY: begin
        held = 2'd0;
        if (arrive) begin
          dout_next  = rdata;
          state_next = ONE;
        end
      end
      ONE: begin
        held = 2'd1;
        if (arrive && pop) begin
          dout_next = rdata;
        end else if (arrive) begin
          skid_next  = rdata;
          state_next = TWO;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        held = 2'd2;
        if (pop) begin
          dout_next  = skid_reg;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-domain pointer controller of the async FIFO with FWFT output stage.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic [ADDR_W:0]   wptr_gray_sync,
  output logic [ADDR_W:0]   rptr_gray,
  output logic              rempty,
  output logic [ADDR_W:0]   rlevel,
  output logic              ralmost_empty,
  fifo_read_ctrl_if.master  bus
);

  logic [ADDR_W:0] rptr_bin_reg, rptr_bin_next;
  logic [ADDR_W:0] rptr_gray_reg;
  logic [ADDR_W:0] rlevel_reg, rlevel_next;
  logic            ralmost_empty_reg;
  logic            can_issue;
  logic            ren;

  assign rempty = (rptr_gray_reg == wptr_gray_sync);
  assign ren    = ~rempty & ~rrst & can_issue;

  assign rptr_bin_next = rptr_bin_reg + {{ADDR_W{1'b0}}, ren};
  assign rlevel_next   = gray2bin(wptr_gray_sync) - rptr_bin_next;

  assign bus.ren       = ren;
  assign bus.raddr     = rptr_bin_reg[ADDR_W-1:0];
  assign rptr_gray     = rptr_gray_reg;
  assign rlevel        = rlevel_reg;
  assign ralmost_empty = ralmost_empty_reg;

  // Gray pointer is built from the next binary value so it never lags rptr_bin.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rptr_bin_reg      <= '0;
      rptr_gray_reg     <= '0;
      rlevel_reg        <= '0;
      ralmost_empty_reg <= 1'b1;
    end else begin
      rptr_bin_reg      <= rptr_bin_next;
      rptr_gray_reg     <= bin2gray(rptr_bin_next);
      rlevel_reg        <= rlevel_next;
      ralmost_empty_reg <= (rlevel_next <= (ADDR_W+1)'(AEMPTY_THRESH));
    end
  end

  fifo_out_skid #(
    .DATA_W (DATA_W)
  ) u_out_skid (
    .rclk       (rclk),
    .rrst       (rrst),
    .fetch      (ren),
    .rdata      (bus.rdata),
    .rready     (bus.rready),
    .dout       (bus.dout),
    .dout_valid (bus.dout_valid),
    .can_issue  (can_issue)
  );

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with a registered-read RAM model.
module tb_fifo_read_ctrl;

  logic       rclk;
  logic       rrst;
  logic [3:0] wptr_gray_sync;
  logic [3:0] rptr_gray;
  logic       rempty;
  logic [3:0] rlevel;
  logic       ralmost_empty;
  logic [7:0] mem [0:7];
  int         checks;
  int         failures;
  int         n_ren;

  fifo_read_ctrl_if #(.ADDR_W(3), .DATA_W(8)) bus ();

  fifo_read_ctrl #(
    .ADDR_W        (3),
    .DATA_W        (8),
    .AEMPTY_THRESH (1)
  ) dut (
    .rclk           (rclk),
    .rrst           (rrst),
    .wptr_gray_sync (wptr_gray_sync),
    .rptr_gray      (rptr_gray),
    .rempty         (rempty),
    .rlevel         (rlevel),
    .ralmost_empty  (ralmost_empty),
    .bus            (bus)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  always @(posedge rclk) begin
    if (bus.ren) bus.rdata <= mem[bus.raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge rclk);
    #1;
  endtask

  task automatic mid();
    @(negedge rclk);
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    wptr_gray_sync = 4'b0000;
    bus.rready = 1'b0;
    cyc();
    cyc();
    rrst = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;

    // 1. Reset
    rrst = 1'b1;
    wptr_gray_sync = 4'b0000;
    bus.rready = 1'b0;
    cyc();
    mid();
    chk("rst_ren_during", 32'(bus.ren), 32'd0);
    cyc();
    rrst = 1'b0;
    mid();
    chk("rst_rempty", 32'(rempty), 32'd1);
    chk("rst_ren", 32'(bus.ren), 32'd0);
    chk("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
    chk("rst_rptr_gray", 32'(rptr_gray), 32'd0);
    chk("rst_rlevel", 32'(rlevel), 32'd0);
    chk("rst_ralmost_empty", 32'(ralmost_empty), 32'd1);

    // 2. Single word, no consumer
    cyc();
    mem[0] = 8'hA5;
    wptr_gray_sync = 4'b0001;
    mid();
    chk("single_ren", 32'(bus.ren), 32'd1);
    chk("single_raddr", 32'(bus.raddr), 32'd0);
    cyc();
    mid();
    chk("single_rempty_c1", 32'(rempty), 32'd1);
    chk("single_rptr_gray_c1", 32'(rptr_gray), 32'h1);
    chk("single_ren_c1", 32'(bus.ren), 32'd0);
    cyc();
    for (int c = 2; c < 6; c++) begin
      mid();
      chk("single_dout_valid", 32'(bus.dout_valid), 32'd1);
      chk("single_dout", 32'(bus.dout), 32'hA5);
      cyc();
    end

    // 3. Eight-word stream at full rate
    do_reset();
    for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
    wptr_gray_sync = 4'b1100;
    bus.rready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      mid();
      chk("stream_ren", 32'(bus.ren), (c < 8) ? 32'd1 : 32'd0);
      if (c < 8) chk("stream_raddr", 32'(bus.raddr), 32'(c));
      chk("stream_dout_valid", 32'(bus.dout_valid), (c >= 2 && c < 10) ? 32'd1 : 32'd0);
      if (c >= 2 && c < 10) chk("stream_dout", 32'(bus.dout), 32'h10 + 32'(c - 2));
      cyc();
    end
    mid();
    chk("stream_rptr_gray", 32'(rptr_gray), 32'hC);
    chk("stream_rempty", 32'(rempty), 32'd1);

    // 4. Backpressure with five words available
    do_reset();
    for (int i = 0; i < 8; i++) mem[i] = 8'h40 + 8'(i);
    wptr_gray_sync = 4'b0111;
    n_ren = 0;
    for (int c = 0; c < 6; c++) begin
      mid();
      if (bus.ren) begin
        chk("bp_raddr", 32'(bus.raddr), 32'(n_ren));
        n_ren++;
      end
      cyc();
    end
    chk("bp_ren_count", 32'(n_ren), 32'd2);
    mid();
    chk("bp_two_valid", 32'(bus.dout_valid), 32'd1);
    chk("bp_two_dout", 32'(bus.dout), 32'h40);
    chk("bp_rlevel", 32'(rlevel), 32'd3);
    chk("bp_ren_stalled", 32'(bus.ren), 32'd0);
    bus.rready = 1'b1;
    #1;
    chk("bp_pop_ren", 32'(bus.ren), 32'd1);
    chk("bp_pop_raddr", 32'(bus.raddr), 32'd2);
    cyc();
    bus.rready = 1'b0;
    mid();
    chk("bp_after_dout", 32'(bus.dout), 32'h41);
    chk("bp_after_ren", 32'(bus.ren), 32'd0);

    // 5. Pointer wrap from rptr_bin=15 back to 0
    do_reset();
    for (int i = 0; i < 8; i++) mem[i] = 8'hC0 + 8'(i);
    bus.rready = 1'b1;
    wptr_gray_sync = 4'b1100;
    repeat (12) cyc();
    wptr_gray_sync = 4'b1000;
    repeat (12) cyc();
    mid();
    chk("wrap_pre_rptr_gray", 32'(rptr_gray), 32'h8);
    chk("wrap_pre_rempty", 32'(rempty), 32'd1);
    chk("wrap_pre_dout_valid", 32'(bus.dout_valid), 32'd0);
    cyc();
    wptr_gray_sync = 4'b0000;
    mid();
    chk("wrap_ren", 32'(bus.ren), 32'd1);
    chk("wrap_raddr", 32'(bus.raddr), 32'd7);
    cyc();
    mid();
    chk("wrap_rptr_gray", 32'(rptr_gray), 32'h0);
    chk("wrap_rempty", 32'(rempty), 32'd1);
    chk("wrap_rlevel", 32'(rlevel), 32'd0);
    chk("wrap_ren_after", 32'(bus.ren), 32'd0);
    cyc();
    mid();
    chk("wrap_dout_valid", 32'(bus.dout_valid), 32'd1);
    chk("wrap_dout", 32'(bus.dout), 32'hC7);

    // 6. Reset with a word held and another in flight
    do_reset();
    mem[0] = 8'h11;
    mem[1] = 8'h22;
    wptr_gray_sync = 4'b0001;
    repeat (3) cyc();
    mid();
    chk("mrst_one_valid", 32'(bus.dout_valid), 32'd1);
    chk("mrst_one_dout", 32'(bus.dout), 32'h11);
    wptr_gray_sync = 4'b0011;
    #1;
    chk("mrst_ren", 32'(bus.ren), 32'd1);
    chk("mrst_raddr", 32'(bus.raddr), 32'd1);
    cyc();
    rrst = 1'b1;
    wptr_gray_sync = 4'b0000;
    mid();
    chk("mrst_ren_in_reset", 32'(bus.ren), 32'd0);
    cyc();
    rrst = 1'b0;
    mid();
    chk("mrst_dout_valid", 32'(bus.dout_valid), 32'd0);
    chk("mrst_rptr_gray", 32'(rptr_gray), 32'd0);
    chk("mrst_dout", 32'(bus.dout), 32'd0);
    repeat (3) begin
      cyc();
      mid();
      chk("mrst_no_flight_valid", 32'(bus.dout_valid), 32'd0);
      chk("mrst_no_flight_dout", 32'(bus.dout), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
